// File: rtl/digit_scan_scheduler.sv
// Scans the four wash-timer digits onto one shared segment driver, with a dark gap before each lit slot.
// All outputs registered; masked digits are skipped and frame_done marks each completed frame.
module digit_scan_scheduler #(
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_mask,
    output logic       low_one_tenth_sec,
    output logic       low_sec,
    output logic       low_ten_sec,
    output logic       low_min,
    output logic [1:0] scan_idx,
    output logic       frame_done
);

    localparam int MAX_CYCLES = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx_nxt;
    logic          fd_nxt;
    logic [3:0]    sel, sel_nxt;

    function automatic logic [1:0] lowest_set(input logic [3:0] m);
        lowest_set = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_set = 2'(i);
        end
    endfunction

    // Nearest set bit strictly above cur with wrap; cur itself is the last resort.
    function automatic logic [1:0] next_set(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] j;
        next_set = cur;
        for (int i = 4; i >= 1; i--) begin
            j = cur + 2'(i);
            if (m[j]) next_set = j;
        end
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = scan_idx;
        fd_nxt    = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|digit_mask) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        idx_nxt   = lowest_set(digit_mask);
                    end
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = SHOW;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt_nxt = '0;
                        if (|digit_mask) begin
                            state_nxt = BLANK;
                            idx_nxt   = next_set(digit_mask, scan_idx);
                            fd_nxt    = (idx_nxt <= scan_idx);
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
        // Selects are decoded from the next state so they land on the same edge as it.
        sel_nxt = 4'hF;
        if (state_nxt == SHOW) sel_nxt[idx_nxt] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            scan_idx   <= 2'd0;
            frame_done <= 1'b0;
            sel        <= 4'hF;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            scan_idx   <= idx_nxt;
            frame_done <= fd_nxt;
            sel        <= sel_nxt;
        end
    end

    assign low_one_tenth_sec = sel[0];
    assign low_sec           = sel[1];
    assign low_ten_sec       = sel[2];
    assign low_min           = sel[3];

endmodule
